// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Store-side write buffer between the MEM stage and the data memory port.
//   sw/sh/sb requests are lane-aligned and given byte enables. Misaligned or
//   reserved-type requests are flagged and dropped. Accepted writes queue in a
//   DEPTH-entry FIFO and drain to memory in order. Loads whose word matches a
//   resident entry are flagged so the hazard unit can stall them.
//
//   Optional feature macro: STORE_WB_COALESCE_EN
//     When defined, an aligned store that targets the tail entry's word merges
//     into that entry (only while count>=2, so the tail is never the head that
//     memory may be consuming). A merge is accepted even when the buffer is full.
//
// Handshakes:
//   store side : a request is taken on a rising edge where
//                st_valid & st_ready & !st_misalign. st_ready does not depend on
//                a pop in the same cycle (no bypass when full).
//   memory side: the head is transferred on a rising edge where
//                mem_valid & mem_ready. While mem_valid=1 and mem_ready=0 the
//                head fields hold. mem_ready is ignored when mem_valid=0.
//
// Ports:
//   clk, reset             clock; synchronous active-low reset
//   st_valid/st_type/st_addr/st_data   store request (type 00 sw, 01 sh, 10 sb)
//   st_ready, st_misalign  buffer can accept / request is illegal (dropped)
//   ld_valid, ld_addr      load in MEM stage
//   ld_conflict            load word matches a pending store
//   mem_valid/mem_addr/mem_wdata/mem_be, mem_ready   memory write port
//   count, empty           occupancy
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    st_type,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_misalign,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_conflict,
  output logic          mem_valid,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ready,
  output logic [AW:0]   count,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;

  logic [31:0]   al_data;
  logic [3:0]    al_be;
  logic          merge_hit;
  logic          push;
  logic          pop;
  logic          ld_hit;

  // Low address bits of a load never matter: matching is per word.
  logic          unused_ld_bits;
  assign unused_ld_bits = &{1'b0, ld_addr[1:0]};

  // Lane alignment of the store data.
  always_comb begin
    al_data = '0;
    al_be   = '0;
    case (st_type)
      2'b00: begin
        al_data = st_data;
        al_be   = 4'b1111;
      end
      2'b01: begin
        al_data = {2{st_data[15:0]}};
        al_be   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        al_data = {4{st_data[7:0]}};
        al_be   = 4'b0001 << st_addr[1:0];
      end
      default: begin
        al_data = '0;
        al_be   = '0;
      end
    endcase
  end

  assign st_misalign = st_valid & (((st_type == 2'b00) & (st_addr[1:0] != 2'b00)) |
                                   ((st_type == 2'b01) & st_addr[0]) |
                                   (st_type == 2'b11));

`ifdef STORE_WB_COALESCE_EN
  logic [AW-1:0] tail_ptr;
  assign tail_ptr  = wr_ptr - AW'(1);
  // count>=2 guarantees the tail slot holds a valid entry that is not the head.
  assign merge_hit = st_valid & ~st_misalign & (cnt_q >= (AW+1)'(2)) &
                     (addr_q[tail_ptr] == st_addr[31:2]);
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready  = (cnt_q != FULL_CNT) | merge_hit;
  assign push      = st_valid & st_ready & ~st_misalign & ~merge_hit;
  assign empty     = (cnt_q == '0);
  assign mem_valid = ~empty;
  assign pop       = mem_valid & mem_ready;
  assign count     = cnt_q;

  // Head outputs are forced to zero when nothing is resident so stale slot
  // contents never reach the port.
  assign mem_addr  = mem_valid ? {addr_q[rd_ptr], 2'b00} : '0;
  assign mem_wdata = mem_valid ? data_q[rd_ptr] : '0;
  assign mem_be    = mem_valid ? be_q[rd_ptr]   : '0;

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; no reset needed since residency is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      addr_q[wr_ptr] <= st_addr[31:2];
      data_q[wr_ptr] <= al_data;
      be_q[wr_ptr]   <= al_be;
    end
`ifdef STORE_WB_COALESCE_EN
    else if (reset && merge_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (al_be[b]) data_q[tail_ptr][8*b +: 8] <= al_data[8*b +: 8];
      end
      be_q[tail_ptr] <= be_q[tail_ptr] | al_be;
    end
`endif
  end

  // A slot is resident when its distance from rd_ptr is below count.
  always_comb begin
    logic [AW-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (({1'b0, off} < cnt_q) && (addr_q[i] == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

  assign ld_conflict = ld_valid & ld_hit;

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef STORE_WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [AW:0] count;
  logic        empty;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready),
    .count(count), .empty(empty)
  );

  int total;
  int bad;

  // ---------------- reference model ----------------
  // Each entry: [65:36] word address, [35:4] data, [3:0] byte enables.
  logic [65:0] exp_q[$];

  function automatic logic [65:0] align_entry(logic [1:0] t, logic [31:0] a, logic [31:0] d);
    logic [31:0] data;
    logic [3:0]  be;
    data = 32'h0;
    be   = 4'h0;
    if (t == 2'd0) begin
      data = d;
      be   = 4'hF;
    end else if (t == 2'd1) begin
      data = {d[15:0], d[15:0]};
      be   = (a[1] == 1'b1) ? 4'hC : 4'h3;
    end else if (t == 2'd2) begin
      data = {d[7:0], d[7:0], d[7:0], d[7:0]};
      be   = 4'(1 << a[1:0]);
    end
    return {a[31:2], data, be};
  endfunction

  function automatic bit model_misalign();
    return st_valid && ((st_type == 2'd3) ||
                        (st_type == 2'd0 && st_addr[1:0] != 2'd0) ||
                        (st_type == 2'd1 && st_addr[0]));
  endfunction

  function automatic bit model_merge();
    int n;
    n = exp_q.size();
    if (!COAL || !st_valid || model_misalign() || n < 2) return 1'b0;
    return exp_q[n-1][65:36] == st_addr[31:2];
  endfunction

  // Expected {mem_valid, mem_addr, mem_wdata, mem_be, count, empty, st_ready, st_misalign, ld_conflict}
  function automatic logic [75:0] model_outs();
    logic [65:0] head;
    bit          mv;
    bit          ldc;
    int          n;
    n    = exp_q.size();
    mv   = (n != 0);
    head = mv ? exp_q[0] : 66'h0;
    ldc  = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][65:36] == ld_addr[31:2]) ldc = 1'b1;
    return {mv, (mv ? {head[65:36], 2'b00} : 32'h0), head[35:4], head[3:0],
            3'(n), (n == 0), ((n < DEPTH) || model_merge()), model_misalign(),
            (ld_valid && ldc)};
  endfunction

  // Advance one clock and update the model with what the DUT should have done.
  task automatic tick();
    bit          mis, mrg, psh, pp;
    logic [65:0] ent, t;
    int          n;
    n   = exp_q.size();
    mis = model_misalign();
    mrg = model_merge();
    ent = align_entry(st_type, st_addr, st_data);
    psh = st_valid && !mis && !mrg && (n < DEPTH);
    pp  = (n != 0) && mem_ready;
    @(posedge clk);
    #1;
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (mrg) begin
        t = exp_q[n-1];
        for (int b = 0; b < 4; b++) begin
          if (ent[b]) begin
            t[4+8*b +: 8] = ent[4+8*b +: 8];
            t[b] = 1'b1;
          end
        end
        exp_q[n-1] = t;
      end
      if (pp)  void'(exp_q.pop_front());
      if (psh) exp_q.push_back(ent);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drive_idle();
    st_valid  = 1'b0;
    st_type   = 2'd0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    ld_valid  = 1'b0;
    ld_addr   = 32'h0;
    mem_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be} !== 69'h0) begin
      bad++;
      $display("FAIL reset_mem got=%h want=0", {mem_valid, mem_addr, mem_wdata, mem_be});
    end
    total++;
    if ({count, empty, st_ready} !== 5'b00011) begin
      bad++;
      $display("FAIL reset_occ got=%b want=00011", {count, empty, st_ready});
    end
  endtask

  task automatic test_sw_basic();
    drive_store(2'd0, 32'h100, 32'hDEADBEEF);
    mem_ready = 1'b1;
    tick();
    st_valid = 1'b0;
    #1;
    total++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) begin
      bad++;
      $display("FAIL sw_head got=%h want=%h", {mem_valid, mem_addr, mem_wdata, mem_be},
               {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    end
    tick();
    #1;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL sw_drained got=%b want=1", empty);
    end
  endtask

  task automatic test_sb_sh();
    mem_ready = 1'b0;
    drive_store(2'd2, 32'h203, 32'h000000A5);
    tick();
    drive_store(2'd1, 32'h206, 32'h00001234);
    tick();
    st_valid = 1'b0;
    #1;
    total++;
    if ({count, mem_addr, mem_wdata, mem_be} !== {3'd2, 32'h200, 32'hA5A5A5A5, 4'b1000}) begin
      bad++;
      $display("FAIL sb_entry got=%h want=%h", {count, mem_addr, mem_wdata, mem_be},
               {3'd2, 32'h200, 32'hA5A5A5A5, 4'b1000});
    end
    mem_ready = 1'b1;
    tick();
    #1;
    total++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h204, 32'h12341234, 4'b1100}) begin
      bad++;
      $display("FAIL sh_entry got=%h want=%h", {mem_valid, mem_addr, mem_wdata, mem_be},
               {1'b1, 32'h204, 32'h12341234, 4'b1100});
    end
    tick();
    mem_ready = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL sbsh_drained got=%b want=1", empty);
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  types [3];
    logic [31:0] addrs [3];
    types = '{2'd0, 2'd1, 2'd3};
    addrs = '{32'h101, 32'h103, 32'h100};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_store(types[i], addrs[i], $urandom);
      #1;
      total++;
      if (st_misalign !== 1'b1) begin
        bad++;
        $display("FAIL misalign_flag idx=%0d got=%b want=1", i, st_misalign);
      end
      tick();
      #1;
      total++;
      if ({count, mem_valid} !== 4'b0000) begin
        bad++;
        $display("FAIL misalign_nostate idx=%0d got=%b want=0000", i, {count, mem_valid});
      end
    end
    st_valid  = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    int guard;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(2'd0, 32'h500 + 32'(4*i), $urandom);
      tick();
    end
    st_valid = 1'b0;
    #1;
    total++;
    if ({count, st_ready} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL full_state got=%b want=1000", {count, st_ready});
    end
    drive_store(2'd0, 32'h520, $urandom);
    mem_ready = 1'b1;
    #1;
    total++;
    if (st_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_no_bypass got=%b want=0", st_ready);
    end
    tick();
    st_valid = 1'b0;
    #1;
    total++;
    if ({count, mem_addr} !== {3'd3, 32'h504}) begin
      bad++;
      $display("FAIL fifth_dropped got=%h want=%h", {count, mem_addr}, {3'd3, 32'h504});
    end
    for (int i = 0; i < 6; i++) begin
      drive_store(2'd0, 32'h540 + 32'(4*i), $urandom);
      mem_ready = 1'b1;
      #1;
      total++;
      if ({count, mem_addr, mem_wdata, mem_be} !== {3'd3, exp_q[0][65:36], 2'b00, exp_q[0][35:0]}) begin
        bad++;
        $display("FAIL wrap_head i=%0d got=%h want=%h", i, {count, mem_addr, mem_wdata, mem_be},
                 {3'd3, exp_q[0][65:36], 2'b00, exp_q[0][35:0]});
      end
      tick();
    end
    st_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      #1;
      total++;
      if ({mem_addr, mem_wdata, mem_be} !== {exp_q[0][65:36], 2'b00, exp_q[0][35:0]}) begin
        bad++;
        $display("FAIL wrap_drain got=%h want=%h", {mem_addr, mem_wdata, mem_be},
                 {exp_q[0][65:36], 2'b00, exp_q[0][35:0]});
      end
      tick();
      guard++;
    end
    #1;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_empty got=%b want=1", empty);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_ld_conflict();
    mem_ready = 1'b0;
    drive_store(2'd0, 32'h300, $urandom);
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h302;
    #1;
    total++;
    if (ld_conflict !== 1'b1) begin
      bad++;
      $display("FAIL ld_hit got=%b want=1", ld_conflict);
    end
    ld_addr = 32'h304;
    #1;
    total++;
    if (ld_conflict !== 1'b0) begin
      bad++;
      $display("FAIL ld_other_word got=%b want=0", ld_conflict);
    end
    ld_addr   = 32'h302;
    mem_ready = 1'b1;
    #1;
    total++;
    if (ld_conflict !== 1'b1) begin
      bad++;
      $display("FAIL ld_popping_head got=%b want=1", ld_conflict);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    total++;
    if (ld_conflict !== 1'b0) begin
      bad++;
      $display("FAIL ld_after_pop got=%b want=0", ld_conflict);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(2'd0, 32'h700 + 32'(4*i), $urandom);
      tick();
    end
    st_valid  = 1'b0;
    reset     = 1'b0;
    mem_ready = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({mem_valid, count, st_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_midflight got=%b want=00001", {mem_valid, count, st_ready});
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_coalesce();
    int guard;
    mem_ready = 1'b0;
    drive_store(2'd0, 32'h600, 32'h01020304);
    tick();
    drive_store(2'd2, 32'h40C, 32'h00000011);
    tick();
    drive_store(2'd2, 32'h40D, 32'h00000022);
    tick();
    st_valid = 1'b0;
    #1;
    total++;
`ifdef STORE_WB_COALESCE_EN
    if (count !== 3'd2) begin
      bad++;
      $display("FAIL coal_count got=%0d want=2", count);
    end
`else
    if (count !== 3'd3) begin
      bad++;
      $display("FAIL coal_count got=%0d want=3", count);
    end
`endif
    mem_ready = 1'b1;
    tick();
    #1;
    total++;
`ifdef STORE_WB_COALESCE_EN
    if ({mem_addr, mem_wdata[15:0], mem_be} !== {32'h40C, 16'h2211, 4'b0011}) begin
      bad++;
      $display("FAIL coal_merge got=%h want=%h", {mem_addr, mem_wdata[15:0], mem_be},
               {32'h40C, 16'h2211, 4'b0011});
    end
`else
    if ({mem_addr, mem_wdata, mem_be} !== {32'h40C, 32'h11111111, 4'b0001}) begin
      bad++;
      $display("FAIL coal_nomerge got=%h want=%h", {mem_addr, mem_wdata, mem_be},
               {32'h40C, 32'h11111111, 4'b0001});
    end
`endif
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      tick();
      guard++;
    end
    #1;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL coal_drained got=%b want=1", empty);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [75:0] exp_v;
    logic [75:0] got_v;
    for (int n = 0; n < 400; n++) begin
      st_valid  = ($urandom_range(0, 3) != 0);
      st_type   = 2'($urandom_range(0, 3));
      st_addr   = 32'h800 + 32'($urandom_range(0, 15));
      st_data   = $urandom;
      ld_valid  = ($urandom_range(0, 1) != 0);
      ld_addr   = 32'h800 + 32'($urandom_range(0, 19));
      mem_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 60) != 0);
      #1;
      exp_v = model_outs();
      got_v = {mem_valid, mem_addr, mem_wdata, mem_be, count, empty, st_ready, st_misalign, ld_conflict};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", n, got_v, exp_v);
      end
      tick();
    end
    reset = 1'b1;
    drive_idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_sw_basic();
    test_sb_sh();
    test_misalign();
    test_full_wrap();
    test_ld_conflict();
    test_reset_midflight();
    test_coalesce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Store-side counterpart of the writeback load-extension path.
- Takes sw/sh/sb requests from the MEM stage and aligns store data into byte lanes. Generates 4-bit byte enables and detects misaligned stores.
- Queues aligned writes in a small FIFO and drains them to the data memory port under a valid/ready handshake.
- Flags loads that hit a pending store word so the hazard unit can stall them.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- st_valid  in  1  store request present.
- st_type  in  2  00 sw, 01 sh, 10 sb, 11 reserved.
- st_addr  in  32  byte address.
- st_data  in  32  unaligned rt value.
- st_ready  out  1  buffer can accept a new entry.
- st_misalign  out  1  combinational; request is illegal and is dropped.
- ld_valid  in  1  a load is in the MEM stage.
- ld_addr  in  32  load byte address.
- ld_conflict  out  1  load word matches a pending store.
- mem_valid  out  1  head entry is presented to memory.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables byte lane i.
- mem_ready  in  1  memory accepts the head this cycle.
- count  out  AW+1  number of occupied entries.
- empty  out  1  count==0.

Behaviour:
- Reset:
  - reset==0 at a clock edge clears wr_ptr, rd_ptr and count.
  - All pending entries are discarded, including one mid-handshake.
  - Next cycle: mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, count=0, empty=1, st_ready=1.
- Alignment (combinational, using a=st_addr[1:0]):
  - sw: data=st_data, be=1111.
  - sh: data={2{st_data[15:0]}}, be=0011 if a[1]=0, else 1100.
  - sb: data={4{st_data[7:0]}}, be=0001<<a.
- Misalignment:
  - st_misalign=st_valid & ((sw & a!=0) | (sh & a[0]) | type==11).
  - A misaligned request never enqueues and never alters state.
- Push:
  - Occurs when st_valid & st_ready & !st_misalign.
  - The entry {word addr, data, be} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- st_ready is count<DEPTH.
  - No same-cycle bypass: when full, st_ready=0 even if a pop occurs in that cycle.
- Drain side:
  - mem_valid=!empty.
  - mem_addr, mem_wdata and mem_be reflect the head entry at rd_ptr.
  - Pop occurs on mem_valid & mem_ready; rd_ptr increments modulo DEPTH.
  - Head fields hold stable while mem_valid=1 and mem_ready=0.
- Latency: a store pushed into an empty buffer appears on mem_valid the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: pointers are AW bits wide and wrap naturally; full/empty are decided from count only.
- ld_conflict:
  - ld_valid & (some resident entry has addr[31:2]==ld_addr[31:2]).
  - The head being popped this cycle still counts, which is conservative.
  - A store being pushed in the same cycle does not count.
- mem_ready while mem_valid=0 is ignored.

Optional Feature:
- Macro: STORE_WB_COALESCE_EN.
- Defined:
  - A valid aligned store merges into the tail entry instead of pushing when count>=2 and the tail word address equals st_addr[31:2].
  - The tail entry is never the head while count>=2.
  - Merge: tail be |= new be; bytes with new be set are replaced by the new data.
  - count and wr_ptr are unchanged.
  - A merge is accepted even when full; st_ready is then 1 for that request.
- Undefined: every accepted store occupies its own entry; no merge logic is present.

Test Plan:
- Reset, then sw addr 0x100 data 0xDEADBEEF with mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=1111; following cycle empty=1.
- sb addr 0x203 data 0x000000A5, then sh addr 0x206 data 0x00001234 -> entries 0x200/0xA5A5A5A5/1000 and 0x204/0x12341234/1100, drained in order.
- Misaligned requests: sw 0x101, sh 0x103, type 11 -> st_misalign=1 each cycle; count stays 0; mem_valid stays 0.
- mem_ready=0, push 4 sw -> count=4, st_ready=0. Fifth push with mem_ready=1 in the same cycle is not accepted and count becomes 3. Then 6 more push/pop cycles -> pointer wrap with FIFO order preserved.
- Pending sw 0x300; ld 0x302 -> ld_conflict=1; ld 0x304 -> ld_conflict=0. After the pop completes, ld 0x302 -> ld_conflict=0.
- 3 entries pending, reset=0 for one cycle with mem_ready=1 -> mem_valid=0, count=0 next cycle. Under STORE_WB_COALESCE_EN: tail sb 0x40C 0x11, then sb 0x40D 0x22 with count>=2 -> tail be=0011, bytes 0x2211, count unchanged.
